// File: rtl/hack_mem_pkg.sv
// Shared types and widths for the Hack data-RAM path (CPU port, video scanout, RAM macro).
package hack_mem_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the CPU data port, the video scanout reader and the data RAM macro.
interface data_ram_arbiter_if
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // The requesters and the RAM macro together form the master side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the video port has been denied the RAM.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == W'(MAX));

endmodule

// File: rtl/data_ram_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, video gets a forced slot after VID_MAX_WAIT denials.
module data_ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W       = HACK_ADDR_W,
  parameter int DATA_W       = HACK_DATA_W,
  parameter int VID_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  data_ram_arbiter_if.slave bus
);

  owner_t            grant;
  owner_t            rd_owner;
  owner_t            rd_owner_next;
  logic              vid_at_max;
  logic              vid_force;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              we_sel;

  // Clearing whenever video is idle means only back-to-back denials can build up to a forced slot.
  arb_starve_counter #(
    .MAX (VID_MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((grant == OWN_VID) || !bus.vid_req),
    .inc     (bus.vid_req),
    .at_max  (vid_at_max)
  );

  assign vid_force = bus.vid_req && vid_at_max;

  always_comb begin
    grant = OWN_NONE;
    if (vid_force)        grant = OWN_VID;
    else if (bus.cpu_req) grant = OWN_CPU;
    else if (bus.vid_req) grant = OWN_VID;
  end

  // An idle cycle keeps the RAM address stable at the last granted one.
  always_comb begin
    addr_sel  = last_addr;
    we_sel    = 1'b0;
    wdata_sel = '0;
    unique case (grant)
      OWN_CPU: begin
        addr_sel  = bus.cpu_addr;
        we_sel    = bus.cpu_we;
        wdata_sel = bus.cpu_wdata;
      end
      OWN_VID: addr_sel = bus.vid_addr;
      default: ;
    endcase
  end

  always_comb begin
    rd_owner_next = OWN_NONE;
    if (grant == OWN_CPU && !bus.cpu_we) rd_owner_next = OWN_CPU;
    else if (grant == OWN_VID)           rd_owner_next = OWN_VID;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_owner  <= OWN_NONE;
      last_addr <= '0;
    end else begin
      rd_owner  <= rd_owner_next;
      last_addr <= addr_sel;
    end
  end

  // Everything that can disturb the RAM or the CPU pipeline is held quiet during reset.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.vid_gnt   = 1'b0;
    bus.cpu_stall = 1'b0;
    if (reset_n) begin
      bus.ram_addr  = addr_sel;
      bus.ram_we    = we_sel;
      bus.ram_wdata = wdata_sel;
      bus.vid_gnt   = (grant == OWN_VID);
      bus.cpu_stall = bus.cpu_req && (grant != OWN_CPU);
    end
  end

  assign bus.cpu_rvalid = (rd_owner == OWN_CPU);
  assign bus.vid_rvalid = (rd_owner == OWN_VID);
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.vid_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: directed table, multi-cycle corner sequences, random vs. model.
module tb_data_ram_arbiter;
  import hack_mem_pkg::*;

  localparam int AW   = HACK_ADDR_W;
  localparam int DW   = HACK_DATA_W;
  localparam int MAXW = 4;
  localparam int NRND = 1500;

  typedef struct {
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          exp_stall;
    logic          exp_gnt;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic          exp_crv;
    logic          exp_vrv;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  data_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_ram_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .VID_MAX_WAIT (MAXW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle synchronous read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;

  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    ram_q <= ram[bus.ram_addr];
  end

  assign bus.ram_rdata = ram_q;

  // Reference model state, expressed as spec-level quantities.
  int            m_wait;
  int            m_prev_owner;
  logic [DW-1:0] m_prev_data;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] ref_mem [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic cr, logic cw, logic [AW-1:0] ca, logic [DW-1:0] cd,
                              logic vr, logic [AW-1:0] va,
                              logic es, logic eg, logic ew, logic [AW-1:0] ea,
                              logic ecr, logic evr, logic [DW-1:0] erd);
    vec_t v;
    v.cpu_req = cr;   v.cpu_we = cw;   v.cpu_addr = ca; v.cpu_wdata = cd;
    v.vid_req = vr;   v.vid_addr = va;
    v.exp_stall = es; v.exp_gnt = eg;  v.exp_we = ew;   v.exp_addr = ea;
    v.exp_crv = ecr;  v.exp_vrv = evr; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    bus.cpu_req   = v.cpu_req;
    bus.cpu_we    = v.cpu_we;
    bus.cpu_addr  = v.cpu_addr;
    bus.cpu_wdata = v.cpu_wdata;
    bus.vid_req   = v.vid_req;
    bus.vid_addr  = v.vid_addr;
    #1;
  endtask

  task automatic check_output(input string tag, input vec_t v);
    check({tag, ".cpu_stall"},  32'(bus.cpu_stall),  32'(v.exp_stall));
    check({tag, ".vid_gnt"},    32'(bus.vid_gnt),    32'(v.exp_gnt));
    check({tag, ".ram_we"},     32'(bus.ram_we),     32'(v.exp_we));
    check({tag, ".ram_addr"},   32'(bus.ram_addr),   32'(v.exp_addr));
    check({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(v.exp_crv));
    check({tag, ".vid_rvalid"}, 32'(bus.vid_rvalid), 32'(v.exp_vrv));
    if (v.exp_we)  check({tag, ".ram_wdata"}, 32'(bus.ram_wdata), 32'(v.cpu_wdata));
    if (v.exp_crv) check({tag, ".cpu_rdata"}, 32'(bus.cpu_rdata), 32'(v.exp_rdata));
    if (v.exp_vrv) check({tag, ".vid_rdata"}, 32'(bus.vid_rdata), 32'(v.exp_rdata));
  endtask

  task automatic drive_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_wait = 0; m_prev_owner = 0; m_prev_data = '0; m_last_addr = '0;
  endtask

  // Model: fills expectations for v from the arbitration rules, then advances its own state.
  task automatic model_step(inout vec_t v);
    int g;
    g = (v.vid_req && m_wait >= MAXW) ? 2 : v.cpu_req ? 1 : v.vid_req ? 2 : 0;
    v.exp_stall = v.cpu_req && (g != 1);
    v.exp_gnt   = (g == 2);
    v.exp_we    = (g == 1) && v.cpu_we;
    v.exp_addr  = (g == 1) ? v.cpu_addr : (g == 2) ? v.vid_addr : m_last_addr;
    v.exp_crv   = (m_prev_owner == 1);
    v.exp_vrv   = (m_prev_owner == 2);
    v.exp_rdata = m_prev_data;
    m_last_addr = v.exp_addr;
    if (g == 1 && v.cpu_we) ref_mem[v.cpu_addr[3:0]] = v.cpu_wdata;
    if (g == 1 && !v.cpu_we) begin
      m_prev_owner = 1; m_prev_data = ref_mem[v.cpu_addr[3:0]];
    end else if (g == 2) begin
      m_prev_owner = 2; m_prev_data = ref_mem[v.vid_addr[3:0]];
    end else begin
      m_prev_owner = 0;
    end
    m_wait = (!v.vid_req || g == 2) ? 0 : ((m_wait + 1 > MAXW) ? MAXW : m_wait + 1);
  endtask

  initial begin
    vec_t tbl [13];
    vec_t v;
    logic cpu_pend, vid_pend;

    drive_idle();
    ram[15'h0010] = 16'h1234;
    ram[15'h4000] = 16'h00FF;
    ram[15'h0001] = 16'hAAAA;
    ram[15'h0002] = 16'h5555;
    ram[15'h0020] = 16'h0000;

    // cr cw  caddr   cdata    vr  vaddr    st gn we  eaddr    crv vrv rdata
    tbl[0]  = mk(0, 0, 15'h0,  16'h0,    0, 15'h0,    0, 0, 0, 15'h0,    0, 0, 16'h0);
    tbl[1]  = mk(1, 0, 15'h10, 16'h0,    0, 15'h0,    0, 0, 0, 15'h10,   0, 0, 16'h0);
    tbl[2]  = mk(0, 0, 15'h0,  16'h0,    0, 15'h0,    0, 0, 0, 15'h10,   1, 0, 16'h1234);
    tbl[3]  = mk(1, 1, 15'h20, 16'hBEEF, 0, 15'h0,    0, 0, 1, 15'h20,   0, 0, 16'h0);
    tbl[4]  = mk(1, 0, 15'h20, 16'h0,    0, 15'h0,    0, 0, 0, 15'h20,   0, 0, 16'h0);
    tbl[5]  = mk(0, 0, 15'h0,  16'h0,    0, 15'h0,    0, 0, 0, 15'h20,   1, 0, 16'hBEEF);
    tbl[6]  = mk(0, 0, 15'h0,  16'h0,    1, 15'h4000, 0, 1, 0, 15'h4000, 0, 0, 16'h0);
    tbl[7]  = mk(0, 0, 15'h0,  16'h0,    0, 15'h0,    0, 0, 0, 15'h4000, 0, 1, 16'h00FF);
    tbl[8]  = mk(1, 0, 15'h1,  16'h0,    0, 15'h0,    0, 0, 0, 15'h1,    0, 0, 16'h0);
    tbl[9]  = mk(0, 0, 15'h0,  16'h0,    1, 15'h2,    0, 1, 0, 15'h2,    1, 0, 16'hAAAA);
    tbl[10] = mk(1, 0, 15'h1,  16'h0,    0, 15'h0,    0, 0, 0, 15'h1,    0, 1, 16'h5555);
    tbl[11] = mk(0, 0, 15'h0,  16'h0,    1, 15'h2,    0, 1, 0, 15'h2,    1, 0, 16'hAAAA);
    tbl[12] = mk(0, 0, 15'h0,  16'h0,    0, 15'h0,    0, 0, 0, 15'h2,    0, 1, 16'h5555);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("row%0d", i), tbl[i]);
    end

    // Build up two denied video cycles, then reset right after a CPU read grant.
    for (int i = 0; i < 2; i++) begin
      v = mk(1, 0, 15'h10, 16'h0, 1, 15'h4000, 0, 0, 0, 15'h10, 0, 0, 16'h0);
      v.exp_crv = (i == 1);
      v.exp_rdata = 16'h1234;
      apply_stimulus(v);
      check_output($sformatf("prerst%0d", i), v);
    end
    @(negedge clk);
    reset_n = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 15'h55; bus.cpu_wdata = 16'h1111;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("inrst%0d.ram_we", i),     32'(bus.ram_we),     32'd0);
      check($sformatf("inrst%0d.vid_gnt", i),    32'(bus.vid_gnt),    32'd0);
      check($sformatf("inrst%0d.cpu_stall", i),  32'(bus.cpu_stall),  32'd0);
      check($sformatf("inrst%0d.ram_addr", i),   32'(bus.ram_addr),   32'd0);
      check($sformatf("inrst%0d.ram_wdata", i),  32'(bus.ram_wdata),  32'd0);
      check($sformatf("inrst%0d.cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'd0);
      check($sformatf("inrst%0d.vid_rvalid", i), 32'(bus.vid_rvalid), 32'd0);
      @(negedge clk);
      #1;
    end
    drive_idle();
    reset_n = 1'b1;
    #1;
    check("postrst0.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    @(negedge clk);
    #1;
    check("postrst1.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("postrst1.vid_rvalid", 32'(bus.vid_rvalid), 32'd0);

    // Continuous contention from a cleared starvation count: video wins every fifth cycle.
    for (int k = 0; k < 15; k++) begin
      v = mk(1, 0, 15'h10, 16'h0, 1, 15'h4000, 0, 0, 0, 15'h10, 0, 0, 16'h0);
      v.exp_gnt   = (k % 5 == 4);
      v.exp_stall = v.exp_gnt;
      v.exp_addr  = v.exp_gnt ? 15'h4000 : 15'h10;
      v.exp_crv   = (k > 0) && ((k - 1) % 5 != 4);
      v.exp_vrv   = (k > 0) && ((k - 1) % 5 == 4);
      v.exp_rdata = v.exp_vrv ? 16'h00FF : 16'h1234;
      apply_stimulus(v);
      check_output($sformatf("starve%0d", k), v);
    end

    // Randomised traffic on a small address window so read-after-write hazards occur often.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 16'($urandom);
      ram[a] = ref_mem[a];
    end
    cpu_pend = 1'b0;
    vid_pend = 1'b0;
    v = mk(0, 0, 15'h0, 16'h0, 0, 15'h0, 0, 0, 0, 15'h0, 0, 0, 16'h0);
    for (int n = 0; n < NRND; n++) begin
      if (!cpu_pend) begin
        v.cpu_req   = ($urandom_range(0, 9) < 6);
        v.cpu_we    = $urandom_range(0, 1) == 1;
        v.cpu_addr  = 15'($urandom_range(0, 15));
        v.cpu_wdata = 16'($urandom);
      end
      if (!vid_pend) begin
        v.vid_req  = ($urandom_range(0, 9) < 5);
        v.vid_addr = 15'($urandom_range(0, 15));
      end
      model_step(v);
      cpu_pend = v.cpu_req && v.exp_stall;
      vid_pend = v.vid_req && !v.exp_gnt;
      apply_stimulus(v);
      check_output($sformatf("rnd%0d", n), v);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
